// File: rtl/vram_fill_writer.sv
// vram_fill_writer
// Rectangle-fill engine for the 13-bit RGBA framebuffer. Accepts one fill
// command at a time over a valid/ready handshake, clips it to the
// framebuffer, and emits one VRAM write per cycle in row-major order.
// An external arbiter can hold off individual writes with wr_stall without
// losing or repeating a pixel.
module vram_fill_writer #(
    parameter int FB_W    = 160,
    parameter int FB_H    = 120,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 13,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [DATA_W-1:0]  cmd_color,
    input  logic               wr_stall,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Framebuffer limits in the widened coordinate domain and address domain.
    localparam logic [COORD_W:0]  FB_W_C = (COORD_W+1)'(FB_W);
    localparam logic [COORD_W:0]  FB_H_C = (COORD_W+1)'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    state_t               state_reg;
    logic [COORD_W-1:0]   x0_reg;
    logic [COORD_W-1:0]   y0_reg;
    logic [COORD_W-1:0]   cx_reg;
    logic [COORD_W-1:0]   cy_reg;
    logic [COORD_W:0]     x_last_reg;
    logic [COORD_W:0]     y_last_reg;
    logic [ADDR_W-1:0]    row_base_reg;
    logic [DATA_W-1:0]    color_reg;
    logic                 cmd_ready_reg;
    logic                 busy_reg;
    logic                 done_reg;

    // Command decode: clipped end coordinates and emptiness test.
    logic [COORD_W:0]     x_sum;
    logic [COORD_W:0]     y_sum;
    logic [COORD_W:0]     x_end;
    logic [COORD_W:0]     y_end;
    logic                 cmd_empty;
    logic                 accept;

    // Write-phase decode.
    logic                 x_at_end;
    logic                 y_at_end;
    logic                 write_fire;

    // Clip the incoming rectangle against the framebuffer; sums are one bit
    // wider than the coordinates so x+w cannot wrap.
    always_comb begin
        x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
        y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
        x_end     = (x_sum > FB_W_C) ? FB_W_C : x_sum;
        y_end     = (y_sum > FB_H_C) ? FB_H_C : y_sum;
        cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                    ({1'b0, cmd_x} >= FB_W_C) || ({1'b0, cmd_y} >= FB_H_C);
        accept    = cmd_valid && cmd_ready_reg;
    end

    // A write happens whenever the engine is emitting and the arbiter allows it.
    always_comb begin
        write_fire = (state_reg == S_WRITE) && !wr_stall;
        x_at_end   = ({1'b0, cx_reg} == x_last_reg);
        y_at_end   = ({1'b0, cy_reg} == y_last_reg);
    end

    // Main sequencer: command capture, raster walk and handshake outputs.
    // Counters are left in place on the final pixel so the address output
    // always points inside the framebuffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            x0_reg        <= '0;
            y0_reg        <= '0;
            cx_reg        <= '0;
            cy_reg        <= '0;
            x_last_reg    <= '0;
            y_last_reg    <= '0;
            row_base_reg  <= '0;
            color_reg     <= '0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        x0_reg        <= cmd_x;
                        y0_reg        <= cmd_y;
                        color_reg     <= cmd_color;
                        x_last_reg    <= x_end - 1'b1;
                        y_last_reg    <= y_end - 1'b1;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (cmd_empty) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    row_base_reg <= ADDR_W'(y0_reg) * FB_W_A;
                    cx_reg       <= x0_reg;
                    cy_reg       <= y0_reg;
                    state_reg    <= S_WRITE;
                end

                S_WRITE: begin
                    if (write_fire) begin
                        if (x_at_end) begin
                            if (y_at_end) begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                cx_reg       <= x0_reg;
                                cy_reg       <= cy_reg + 1'b1;
                                row_base_reg <= row_base_reg + FB_W_A;
                            end
                        end else begin
                            cx_reg <= cx_reg + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Output mapping: the strobe reacts to wr_stall in the same cycle, the
    // address is the registered row base plus the registered column.
    always_comb begin
        wr_en     = write_fire;
        wr_addr   = row_base_reg + ADDR_W'(cx_reg);
        wr_data   = color_reg;
        cmd_ready = cmd_ready_reg;
        busy      = busy_reg;
        done      = done_reg;
    end

endmodule
